// File: rtl/mem_sequencer.sv
// Per-instruction sequencer for the RV32I core. It fetches the instruction, holds it
// for decode, runs the load/store data phase, and then pulses commit.
module mem_sequencer #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] pc,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic [31:0] instruction,
  output logic [31:0] load_data,
  output logic        pc_en,
  output logic        reg_commit,
  output logic        freeze,
  output logic        access_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_DATA, S_COMMIT
  } state_e;

  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_e      state_q;
  logic        bus_read_q, bus_write_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] instruction_q, load_data_q;
  logic        pc_en_q, reg_commit_q, freeze_q, access_err_q;
  logic [15:0] to_cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic [3:0]  sel_d;
  logic [31:0] wdata_d, load_ext_d;
  logic        dec_err_d, timed_out;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // pc is always fetched word-aligned, so its low bits are deliberately unused
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc[1:0];

  assign timed_out = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  // Decode-cycle checks and lane steering, taken from the live control-unit outputs
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel_d   = 4'hF;
    wdata_d = store_data;
    unique case (funct3[1:0])
      2'b00: begin
        sel_d   = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        sel_d   = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    dec_err_d = (read && write)
             || (read  && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
             || (write && (funct3[2] || funct3 == 3'b011))
             || ((read || write) && ((funct3[1:0] == 2'b01 && addr[0])
                                  || (funct3 == 3'b010 && addr[1:0] != 2'b00)));
  end

  // Load lane extraction from the bus word, using the sampled access size and lane
  always_comb begin
    byte_v = bus_rdata[7:0];
    unique case (lane_q)
      2'd1:    byte_v = bus_rdata[15:8];
      2'd2:    byte_v = bus_rdata[23:16];
      2'd3:    byte_v = bus_rdata[31:24];
      default: ;
    endcase
    half_v = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (funct3_q[1:0])
      2'b00:   load_ext_d = funct3_q[2] ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_ext_d = funct3_q[2] ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_ext_d = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state is assigned only with <=, so every read sees the pre-edge value.
    if (!reset) begin
      state_q       <= S_IDLE;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_sel_q     <= '0;
      instruction_q <= '0;
      load_data_q   <= '0;
      pc_en_q       <= 1'b0;
      reg_commit_q  <= 1'b0;
      freeze_q      <= 1'b1;
      access_err_q  <= 1'b0;
      to_cnt_q      <= '0;
      funct3_q      <= '0;
      lane_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          access_err_q <= 1'b0;
          if (enable) begin
            state_q    <= S_FETCH;
            bus_read_q <= 1'b1;
            bus_addr_q <= {pc[31:2], 2'b00};
            bus_sel_q  <= 4'hF;
            to_cnt_q   <= '0;
          end
        end
        S_FETCH: begin
          if (bus_ack) begin
            instruction_q <= bus_rdata;
            bus_read_q    <= 1'b0;
            bus_addr_q    <= '0;
            bus_sel_q     <= '0;
            state_q       <= S_DECODE;
          end else if (timed_out) begin
            // Abandon the fetch without committing, so the same pc is fetched again
            bus_read_q   <= 1'b0;
            bus_addr_q   <= '0;
            bus_sel_q    <= '0;
            access_err_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        S_DECODE: begin
          funct3_q <= funct3;
          lane_q   <= addr[1:0];
          if (!read && !write || dec_err_d) begin
            state_q      <= S_COMMIT;
            pc_en_q      <= 1'b1;
            freeze_q     <= 1'b0;
            reg_commit_q <= !dec_err_d;
            access_err_q <= dec_err_d;
          end else begin
            state_q     <= S_DATA;
            bus_read_q  <= read;
            bus_write_q <= write;
            bus_addr_q  <= {addr[31:2], 2'b00};
            bus_sel_q   <= sel_d;
            bus_wdata_q <= write ? wdata_d : 32'd0;
            to_cnt_q    <= '0;
          end
        end
        S_DATA: begin
          if (bus_ack || timed_out) begin
            if (bus_ack && bus_read_q) load_data_q <= load_ext_d;
            bus_read_q   <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_sel_q    <= '0;
            state_q      <= S_COMMIT;
            pc_en_q      <= 1'b1;
            freeze_q     <= 1'b0;
            reg_commit_q <= bus_ack;
            access_err_q <= !bus_ack;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
        end
        S_COMMIT: begin
          pc_en_q      <= 1'b0;
          reg_commit_q <= 1'b0;
          access_err_q <= 1'b0;
          freeze_q     <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_read    = bus_read_q;
  assign bus_write   = bus_write_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_sel     = bus_sel_q;
  assign instruction = instruction_q;
  assign load_data   = load_data_q;
  assign pc_en       = pc_en_q;
  assign reg_commit  = reg_commit_q;
  assign freeze      = freeze_q;
  assign access_err  = access_err_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: fetch, loads, stores, misalignment, timeouts
// and asynchronous reset, with hand-computed expected values.
module tb_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset, enable, read, write, bus_ack;
  logic [31:0] pc, addr, store_data, bus_rdata;
  logic [2:0]  funct3;
  logic        bus_read, bus_write, pc_en, reg_commit, freeze, access_err;
  logic [31:0] bus_addr, bus_wdata, instruction, load_data;
  logic [3:0]  bus_sel;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pc(pc), .read(read), .write(write),
    .funct3(funct3), .addr(addr), .store_data(store_data), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel), .instruction(instruction),
    .load_data(load_data), .pc_en(pc_en), .reg_commit(reg_commit), .freeze(freeze),
    .access_err(access_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From IDLE with enable=1: one FETCH cycle with zero-wait ack, ending in DECODE
  task automatic fetch(input logic [31:0] p, input logic [31:0] ins);
    pc = p;
    step();
    check("fetch_read", bus_read, 1);
    check("fetch_addr", bus_addr, {p[31:2], 2'b00});
    check("fetch_sel", bus_sel, 4'hF);
    bus_ack = 1'b1;
    bus_rdata = ins;
    step();
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    check("decode_instr", instruction, ins);
    check("decode_freeze", freeze, 1);
  endtask

  task automatic set_ctrl(input logic r, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] sd);
    read = r; write = w; funct3 = f; addr = a; store_data = sd;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; pc = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    set_ctrl(0, 0, 3'b000, 32'h0, 32'h0);
    #12;
    check("rst_instr", instruction, 0);
    check("rst_bus_read", bus_read, 0);
    check("rst_bus_sel", bus_sel, 0);
    check("rst_freeze", freeze, 1);
    check("rst_pc_en", pc_en, 0);
    reset = 1'b1;
    enable = 1'b1;

    // Non-memory instruction: commit in the fourth cycle
    fetch(32'h100, 32'h00A00093);
    step();
    check("alu_pc_en", pc_en, 1);
    check("alu_reg_commit", reg_commit, 1);
    check("alu_freeze", freeze, 0);
    check("alu_err", access_err, 0);
    step();
    check("alu_idle_pc_en", pc_en, 0);

    // LB from lane 3, sign-extended
    set_ctrl(1, 0, 3'b000, 32'h203, 32'h0);
    fetch(32'h104, 32'h20300083);
    step();
    check("lb_read", bus_read, 1);
    check("lb_write", bus_write, 0);
    check("lb_addr", bus_addr, 32'h200);
    check("lb_sel", bus_sel, 4'b1000);
    bus_ack = 1'b1; bus_rdata = 32'h80123456;
    step();
    bus_ack = 1'b0;
    check("lb_data", load_data, 32'hFFFFFF80);
    check("lb_commit", reg_commit, 1);
    check("lb_bus_read_off", bus_read, 0);
    step();

    // Same access as LBU, zero-extended
    set_ctrl(1, 0, 3'b100, 32'h203, 32'h0);
    fetch(32'h108, 32'h20304083);
    step();
    check("lbu_sel", bus_sel, 4'b1000);
    bus_ack = 1'b1; bus_rdata = 32'h80123456;
    step();
    bus_ack = 1'b0;
    check("lbu_data", load_data, 32'h00000080);
    step();

    // SH with three wait cycles; ack lands on the last cycle before timeout
    set_ctrl(0, 1, 3'b001, 32'h302, 32'h1234ABCD);
    fetch(32'h10C, 32'h30209123);
    step();
    for (int i = 0; i < 4; i++) begin
      check("sh_write", bus_write, 1);
      check("sh_read", bus_read, 0);
      check("sh_addr", bus_addr, 32'h300);
      check("sh_wdata", bus_wdata, 32'hABCDABCD);
      check("sh_sel", bus_sel, 4'b1100);
      check("sh_freeze", freeze, 1);
      if (i == 3) bus_ack = 1'b1;
      step();
    end
    bus_ack = 1'b0;
    check("sh_commit", reg_commit, 1);
    check("sh_err", access_err, 0);
    check("sh_write_off", bus_write, 0);
    step();

    // SB to lane 1
    set_ctrl(0, 1, 3'b000, 32'h101, 32'h000000EF);
    fetch(32'h110, 32'h0EF000A3);
    step();
    check("sb_sel", bus_sel, 4'b0010);
    check("sb_wdata", bus_wdata, 32'hEFEFEFEF);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("sb_commit", reg_commit, 1);
    step();

    // Misaligned LW: straight to COMMIT with an error, no bus cycle
    set_ctrl(1, 0, 3'b010, 32'h401, 32'h0);
    fetch(32'h114, 32'h40102083);
    step();
    check("lwmis_bus_read", bus_read, 0);
    check("lwmis_err", access_err, 1);
    check("lwmis_commit", reg_commit, 0);
    check("lwmis_pc_en", pc_en, 1);
    step();
    check("lwmis_err_clr", access_err, 0);

    // read and write together is an error
    set_ctrl(1, 1, 3'b010, 32'h400, 32'h0);
    fetch(32'h118, 32'h00000013);
    step();
    check("rw_err", access_err, 1);
    check("rw_commit", reg_commit, 0);
    step();

    // LW with no ack: request dropped after four cycles
    set_ctrl(1, 0, 3'b010, 32'h500, 32'h0);
    fetch(32'h11C, 32'h50002083);
    step();
    for (int i = 0; i < 4; i++) begin
      check("lwto_read", bus_read, 1);
      step();
    end
    check("lwto_read_off", bus_read, 0);
    check("lwto_err", access_err, 1);
    check("lwto_commit", reg_commit, 0);
    check("lwto_pc_en", pc_en, 1);
    step();

    // Fetch timeout: error pulse, back to IDLE without pc_en, then retry
    set_ctrl(0, 0, 3'b000, 32'h0, 32'h0);
    pc = 32'h120;
    step();
    for (int i = 0; i < 4; i++) begin
      check("fto_read", bus_read, 1);
      step();
    end
    check("fto_err", access_err, 1);
    check("fto_pc_en", pc_en, 0);
    check("fto_read_off", bus_read, 0);
    step();
    check("fto_retry_read", bus_read, 1);
    check("fto_retry_addr", bus_addr, 32'h120);
    bus_ack = 1'b1; bus_rdata = 32'h00000013;
    step();
    bus_ack = 1'b0;
    step();
    check("fto_commit", reg_commit, 1);
    step();

    // Reset during a DATA wait drops the request at once
    set_ctrl(0, 1, 3'b010, 32'h600, 32'hDEADBEEF);
    fetch(32'h124, 32'h00000023);
    step();
    check("rstd_write", bus_write, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rstd_write_off", bus_write, 0);
    check("rstd_read_off", bus_read, 0);
    check("rstd_instr", instruction, 0);
    check("rstd_freeze", freeze, 1);
    pc = 32'h700;
    set_ctrl(0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("rstd_refetch_read", bus_read, 1);
    check("rstd_refetch_addr", bus_addr, 32'h700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
